// File: rtl/fifo_sched_pkg.sv
// Shared types, defaults and the round-robin search used by the FIFO write scheduler.
package fifo_sched_pkg;

    localparam int unsigned N_DEF     = 32;
    localparam int unsigned R_DEF     = 4;
    localparam int unsigned M_DEF     = 16;
    localparam int unsigned BURST_DEF = 4;

    // Widest requester vector the search function supports.
    localparam int unsigned R_MAX  = 32;
    localparam int unsigned RIDX_W = $clog2(R_MAX);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    // First requester at or after last+1 (mod nreq); returns 0 when none request.
    function automatic logic [RIDX_W-1:0] next_owner(
        input logic [R_MAX-1:0]  req,
        input logic [RIDX_W-1:0] last,
        input int unsigned       nreq
    );
        logic [RIDX_W-1:0] pick;
        logic [RIDX_W-1:0] idx;
        logic              found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned off = 1; off <= R_MAX; off++) begin
            idx = RIDX_W'((32'(last) + off) % nreq);
            if (off <= nreq && !found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: one-hot and index of the next requester after last_i.
module rr_pick_n
    import fifo_sched_pkg::*;
#(
    parameter  int unsigned r  = R_DEF,
    localparam int unsigned IW = $clog2(r)
) (
    input  logic [r-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [r-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    logic [R_MAX-1:0]  req_pad;
    logic [RIDX_W-1:0] last_pad;
    logic [RIDX_W-1:0] pick;

    always_comb begin
        req_pad          = '0;
        req_pad[r-1:0]   = req_i;
        last_pad         = RIDX_W'(last_i);
        pick             = next_owner(req_pad, last_pad, r);
        idx_o            = IW'(pick);
        vld_o            = |req_i;
        onehot_o         = '0;
        if (vld_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin burst scheduler sharing one FIFO write port among r requesters,
// with occupancy tracking and registered full/empty flags.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter  int unsigned n     = N_DEF,
    parameter  int unsigned r     = R_DEF,
    parameter  int unsigned m     = M_DEF,
    parameter  int unsigned burst = BURST_DEF,
    localparam int unsigned CW    = $clog2(m + 1),
    localparam int unsigned IW    = $clog2(r),
    localparam int unsigned BW    = $clog2(burst + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [r-1:0]  req_i,
    input  logic [n-1:0]  data_i [0:r-1],
    output logic [r-1:0]  ack_o,
    output logic [r-1:0]  gnt_o,
    output logic          wr_o,
    output logic [n-1:0]  wr_data_o,
    input  logic          rd_i,
    output logic [CW-1:0] cnt_o,
    output logic          fl_full,
    output logic          fl_empty
);

    state_t        state_q, state_d;
    logic [r-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          wr_q, wr_d;
    logic [n-1:0]  wr_data_q, wr_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;

    logic [r-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic          wr_acc;
    logic          rd_acc;

    rr_pick_n #(
        .r(r)
    ) u_pick (
        .req_i    (req_i),
        .last_i   (last_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .vld_o    (pick_vld)
    );

    // Accept depends only on registered state so a full FIFO can never be overrun.
    assign ack_o = gnt_q & {r{~full_q}};

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        beat_d    = beat_q;
        wr_data_d = wr_data_q;

        wr_acc = (state_q == BURST) && req_i[owner_q] && !full_q;
        rd_acc = rd_i && !empty_q;

        unique case (state_q)
            IDLE: begin
                if (pick_vld && !full_q) begin
                    state_d = BURST;
                    gnt_d   = pick_onehot;
                    owner_d = pick_idx;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (!req_i[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = owner_q;
                    beat_d  = '0;
                end else if (wr_acc) begin
                    if (beat_q == BW'(burst - 1)) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        last_d  = owner_q;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        wr_d = wr_acc;
        if (wr_acc) begin
            wr_data_d = data_i[owner_q];
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CW'(m));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            last_q    <= IW'(r - 1);
            beat_q    <= '0;
            wr_q      <= 1'b0;
            wr_data_q <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            beat_q    <= beat_d;
            wr_q      <= wr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign wr_o      = wr_q;
    assign wr_data_o = wr_data_q;
    assign cnt_o     = cnt_q;
    assign fl_full   = full_q;
    assign fl_empty  = empty_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Self-checking bench: per-cycle behavioural model plus directed literal checks and random traffic.
module tb_fifo_rr_scheduler;

    localparam int N  = 32;
    localparam int R  = 4;
    localparam int M  = 16;
    localparam int B  = 4;
    localparam int CW = $clog2(M + 1);
    localparam int IW = $clog2(R);

    logic          clk = 1'b0;
    logic          rst_i;
    logic [R-1:0]  req_i;
    logic [N-1:0]  data_i [0:R-1];
    logic [R-1:0]  ack_o;
    logic [R-1:0]  gnt_o;
    logic          wr_o;
    logic [N-1:0]  wr_data_o;
    logic          rd_i;
    logic [CW-1:0] cnt_o;
    logic          fl_full;
    logic          fl_empty;

    always #5 clk = ~clk;

    fifo_rr_scheduler #(
        .n(N), .r(R), .m(M), .burst(B)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .data_i    (data_i),
        .ack_o     (ack_o),
        .gnt_o     (gnt_o),
        .wr_o      (wr_o),
        .wr_data_o (wr_data_o),
        .rd_i      (rd_i),
        .cnt_o     (cnt_o),
        .fl_full   (fl_full),
        .fl_empty  (fl_empty)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the port, how many beats taken, words held in the FIFO.
    bit            m_valid = 1'b0;
    bit            m_burst;
    logic [IW-1:0] m_owner;
    logic [IW-1:0] m_last;
    int            m_beats;
    int            m_cnt;
    bit            m_wr;
    logic [N-1:0]  m_wd;

    task automatic model_step();
        bit full, empty, acc, rdacc, found;
        if (rst_i) begin
            m_valid = 1'b1;
            m_burst = 1'b0;
            m_owner = '0;
            m_last  = IW'(R - 1);
            m_beats = 0;
            m_cnt   = 0;
            m_wr    = 1'b0;
            m_wd    = '0;
        end else if (m_valid) begin
            full  = (m_cnt == M);
            empty = (m_cnt == 0);
            acc   = m_burst && req_i[m_owner] && !full;
            rdacc = rd_i && !empty;
            m_wr  = acc;
            if (acc) m_wd = data_i[m_owner];
            if (acc && !rdacc) m_cnt = m_cnt + 1;
            if (rdacc && !acc) m_cnt = m_cnt - 1;
            if (!m_burst) begin
                if (req_i != '0 && !full) begin
                    found = 1'b0;
                    for (int off = 1; off <= R; off++) begin
                        logic [IW-1:0] k;
                        k = IW'((int'(m_last) + off) % R);
                        if (!found && req_i[k]) begin
                            m_owner = k;
                            found   = 1'b1;
                        end
                    end
                    m_beats = 0;
                    m_burst = 1'b1;
                end
            end else if (!req_i[m_owner]) begin
                m_burst = 1'b0;
                m_last  = m_owner;
            end else if (acc) begin
                m_beats = m_beats + 1;
                if (m_beats == B) begin
                    m_burst = 1'b0;
                    m_last  = m_owner;
                    m_beats = 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_valid) begin
            logic [R-1:0] eg;
            eg = m_burst ? (R'(1) << m_owner) : '0;
            chk("gnt_o", 64'(gnt_o), 64'(eg));
            chk("ack_o", 64'(ack_o), 64'((m_cnt != M) ? eg : '0));
            chk("wr_o", 64'(wr_o), 64'(m_wr));
            chk("wr_data_o", 64'(wr_data_o), 64'(m_wd));
            chk("cnt_o", 64'(cnt_o), 64'(m_cnt));
            chk("fl_full", 64'(fl_full), 64'(m_cnt == M));
            chk("fl_empty", 64'(fl_empty), 64'(m_cnt == 0));
        end
    end

    // A requester may change req/data only when idle, just transferred a beat, or in reset.
    logic [R-1:0] hs_saved;

    task automatic drive(input logic [R-1:0] nreq, input logic nrd, input logic nrst);
        logic [R-1:0] free;
        @(negedge clk);
        free = ~req_i | hs_saved | {R{nrst}};
        for (int k = 0; k < R; k++) begin
            if (free[k]) begin
                req_i[k]  = nreq[k];
                data_i[k] = $urandom;
            end
        end
        rd_i     = nrd;
        rst_i    = nrst;
        hs_saved = req_i & ack_o;
    endtask

    task automatic do_reset();
        drive('0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [$];
        logic [R-1:0] prev_g;
        logic [R-1:0] want;
        bit done;
        int rate;

        rst_i    = 1'b1;
        req_i    = '0;
        rd_i     = 1'b0;
        hs_saved = '0;
        for (int k = 0; k < R; k++) data_i[k] = '0;
        do_reset();

        // Read while empty is ignored.
        drive('0, 1'b1, 1'b0);
        after_edge();
        chk("empty_rd_cnt", 64'(cnt_o), 64'd0);
        chk("empty_rd_flag", 64'(fl_empty), 64'd1);
        chk("empty_rd_full", 64'(fl_full), 64'd0);

        // Single requester: grant one cycle later, one full burst of 4.
        drive(4'b0001, 1'b0, 1'b0);
        after_edge();
        chk("first_gnt", 64'(gnt_o), 64'h1);
        repeat (4) drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        after_edge();
        chk("burst_cnt", 64'(cnt_o), 64'd4);
        chk("burst_idle", 64'(gnt_o), 64'h0);

        // All requesting: owners rotate 0,1,2,3,0.
        do_reset();
        prev_g = '0;
        for (int i = 0; i < 27; i++) begin
            drive(4'b1111, 1'b1, 1'b0);
            after_edge();
            if (gnt_o != '0 && prev_g == '0) begin
                for (int k = 0; k < R; k++) if (gnt_o[k]) seq.push_back(k);
            end
            prev_g = gnt_o;
        end
        chk("rot_count", 64'(seq.size() >= 5), 64'd1);
        if (seq.size() >= 5) begin
            chk("rot0", 64'(seq[0]), 64'd0);
            chk("rot1", 64'(seq[1]), 64'd1);
            chk("rot2", 64'(seq[2]), 64'd2);
            chk("rot3", 64'(seq[3]), 64'd3);
            chk("rot4", 64'(seq[4]), 64'd0);
        end

        // Requester 2 drops after two beats; requester 3 is next.
        do_reset();
        drive(4'b1100, 1'b0, 1'b0);
        after_edge();
        chk("drop_gnt2", 64'(gnt_o), 64'h4);
        drive(4'b1100, 1'b0, 1'b0);
        drive(4'b1100, 1'b0, 1'b0);
        drive(4'b1000, 1'b0, 1'b0);
        after_edge();
        chk("drop_exit", 64'(gnt_o), 64'h0);
        chk("drop_cnt", 64'(cnt_o), 64'd2);
        drive(4'b1000, 1'b0, 1'b0);
        after_edge();
        chk("drop_next3", 64'(gnt_o), 64'h8);

        // Fill to full mid-burst, then one pop lets exactly one beat through.
        do_reset();
        drive(4'b0010, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            drive(4'b0001, 1'b0, 1'b0);
            after_edge();
            if (fl_full) done = 1'b1;
        end
        chk("fill_reached", 64'(done), 64'd1);
        chk("full_cnt", 64'(cnt_o), 64'd16);
        chk("full_gnt_held", 64'(gnt_o), 64'h1);
        chk("full_ack", 64'(ack_o), 64'h0);
        drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0001, 1'b1, 1'b0);
        after_edge();
        chk("pop_cnt", 64'(cnt_o), 64'd15);
        chk("pop_full", 64'(fl_full), 64'd0);
        drive(4'b0001, 1'b0, 1'b0);
        after_edge();
        chk("refill_cnt", 64'(cnt_o), 64'd16);

        // Reset mid-burst at beat 2.
        do_reset();
        drive(4'b0011, 1'b0, 1'b0);
        drive(4'b0011, 1'b0, 1'b0);
        drive(4'b0011, 1'b0, 1'b0);
        drive(4'b0011, 1'b0, 1'b1);
        after_edge();
        chk("rst_gnt", 64'(gnt_o), 64'h0);
        chk("rst_wr", 64'(wr_o), 64'd0);
        chk("rst_cnt", 64'(cnt_o), 64'd0);
        drive(4'b0011, 1'b0, 1'b0);
        after_edge();
        chk("rst_first", 64'(gnt_o), 64'h1);

        // Random traffic with alternating drain rates to visit both full and empty.
        want = '0;
        for (int i = 0; i < 1600; i++) begin
            rate = ((i / 200) % 2 == 0) ? 12 : 60;
            if ($urandom_range(0, 3) == 0) want = R'($urandom_range(0, 15));
            drive(want, ($urandom % 100) < rate, ($urandom % 250) == 0);
        end
        drive('0, 1'b0, 1'b0);
        after_edge();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
